// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit controller.
// Accepts one core request at a time and issues a single word-aligned memory
// access with byte enables and lane-replicated store data. Load data is
// aligned and sign/zero-extended. Grant and read-data waits are bounded by
// TIMEOUT_CYCLES; on expiry the core gets an error response.
//
// Ports
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   req_*            : core request (valid/ready, we, addr, wdata, accessmode, extendmode)
//   resp_*           : one-cycle response (valid, rdata, err)
//   mem_*            : memory request (req/gnt handshake, we, addr, wdata, be, rvalid, rdata)
//
// Build option
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses skip
//                          memory and return resp_err. When undefined, the
//                          offending low address bits are ignored.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_accessmode,
    input  logic        req_extendmode,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  mode_q, mode_d;
    logic        ext_q, ext_d;
    logic        req_ready_q, req_ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    // Request decode: effective lane offset, byte enables, replicated store data
    logic [1:0]  eff_off_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        illegal_c;
    logic        misalign_c;

    always_comb begin
        eff_off_c  = 2'b00;
        be_c       = 4'b1111;
        wdata_c    = req_wdata;
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        case (req_accessmode)
            MODE_BYTE: begin
                eff_off_c = req_addr[1:0];
                be_c      = 4'b0001 << eff_off_c;
                wdata_c   = {4{req_wdata[7:0]}};
            end
            MODE_HALF: begin
                eff_off_c  = {req_addr[1], 1'b0};
                be_c       = 4'b0011 << eff_off_c;
                wdata_c    = {2{req_wdata[15:0]}};
                misalign_c = req_addr[0];
            end
            MODE_WORD: begin
                misalign_c = (req_addr[1:0] != 2'b00);
            end
            default: illegal_c = 1'b1;
        endcase
    end

    // Load alignment and extension
    logic [31:0] shifted_c;
    logic [31:0] load_c;

    always_comb begin
        shifted_c = mem_rdata >> {off_q, 3'b000};
        case (mode_q)
            MODE_BYTE: load_c = ext_q ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                      : {24'h0, shifted_c[7:0]};
            MODE_HALF: load_c = ext_q ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                      : {16'h0, shifted_c[15:0]};
            default:   load_c = shifted_c;
        endcase
    end

    logic trap_c;
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_c = illegal_c | misalign_c;
`else
    assign trap_c = illegal_c;
    logic unused_misalign_c;
    assign unused_misalign_c = misalign_c;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        mode_d       = mode_q;
        ext_d        = ext_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    off_d        = eff_off_c;
                    mode_d       = req_accessmode;
                    ext_d        = req_extendmode;
                    mem_we_d     = req_we;
                    mem_addr_d   = {req_addr[31:2], 2'b00};
                    mem_be_d     = be_c;
                    mem_wdata_d  = wdata_c;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = trap_c;
                    cnt_d        = '0;
                    state_d      = trap_c ? RESP : REQ;
                end
            end
            REQ: begin
                // Grant wins over a coinciding timeout
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = mem_we_q ? RESP : WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp_rdata_d = load_c;
                    state_d      = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        mem_req_d    = (state_d == REQ);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            off_q        <= 2'b00;
            mode_q       <= 2'b00;
            ext_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_be_q     <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            mode_q       <= mode_d;
            ext_q        <= ext_d;
            req_ready_q  <= req_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
